xgmii_tx_frame_arbiter: RTL and testbench
=========================================

# xgmii_tx_frame_arbiter

Frame-granular round-robin arbiter that shares the single 64-bit TX AXI4-Stream input of the XGMII bridge among `NUM_PORTS` independent frame sources. Grants one source at a time and holds the grant until that source's `tlast` beat is accepted, so frames are never interleaved on the XGMII TX path. Also reports mid-frame underruns, which corrupt Ethernet frames downstream, and counts forwarded frames.

## Interface
- `NUM_PORTS`, 4, number of requesting streams, legal range 2..16
- `DATA_WIDTH`, 64, stream data width; only 64 is legal
- `KEEP_WIDTH`, `DATA_WIDTH/8`, tkeep width
- `IDX_WIDTH`, `$clog2(NUM_PORTS)`, grant index width

- `clk`  in  1  single clock for all logic
- `rst`  in  1  asynchronous, active-high reset
- `s_axis_tvalid`  in  NUM_PORTS  per-port valid
- `s_axis_tready`  out  NUM_PORTS  per-port ready
- `s_axis_tdata`  in  NUM_PORTS*DATA_WIDTH  port i at bits [i*64 +: 64]
- `s_axis_tlast`  in  NUM_PORTS  per-port last
- `s_axis_tkeep`  in  NUM_PORTS*KEEP_WIDTH  port i at bits [i*8 +: 8]
- `m_axis_tvalid`/`tdata`/`tlast`/`tkeep`  out  1/64/1/8  to bridge TX stream
- `m_axis_tready`  in  1  from bridge TX stream
- `port_enable`  in  NUM_PORTS  arbitration mask; sampled only in IDLE
- `grant_valid`  out  1  high in ACTIVE
- `grant_index`  out  IDX_WIDTH  currently or last granted port
- `frame_count`  out  32  frames forwarded, counted on accepted tlast beat, wraps
- `error_underrun`  out  1  one-cycle pulse per ACTIVE cycle with granted tvalid low

## Operation
- Two states: IDLE, ACTIVE.
- IDLE: request vector `req = s_axis_tvalid & port_enable`. If nonzero, choose the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_PORTS. Register it into `grant_index` and `last_grant`, then go to ACTIVE. If zero, stay in IDLE. In IDLE all `s_axis_tready` = 0 and `m_axis_tvalid` = 0.
- ACTIVE: `m_axis_*` combinationally mirror the granted port. `s_axis_tready[g] = m_axis_tready`; all other readies are 0. A beat transfers when `m_axis_tvalid & m_axis_tready`. A transferred beat with `tlast` increments `frame_count` and returns the block to IDLE on the next edge.
- `port_enable` changes during ACTIVE do not abort the current frame. They take effect at the next IDLE.
- Underrun: while in ACTIVE with granted `tvalid` = 0, pulse `error_underrun` (registered, one cycle late) every such cycle. The grant is held; no timeout and no abort.
- `tkeep`/`tlast` contents are passed through unchecked. The bridge flags illegal combinations itself.
- `frame_count` is 32-bit unsigned: 0xFFFFFFFF + 1 = 0.

## Timing
- Reset values: state IDLE, `last_grant` = NUM_PORTS-1 (port 0 has first priority), `grant_index` = 0, `grant_valid` = 0, `frame_count` = 0, `error_underrun` = 0, all `s_axis_tready` = 0, `m_axis_tvalid` = 0.
- Arbitration costs one cycle. A request in IDLE at edge n gives `grant_valid` = 1 after edge n. The first beat can transfer in cycle n+1.
- After a tlast transfer at edge m, the block is IDLE in cycle m+1. The next frame's first beat is no earlier than cycle m+2, so there is exactly one bubble cycle between back-to-back frames.
- Data path is zero-latency in ACTIVE. There is no data register, so tdata/tkeep/tlast are combinational from the granted port.
- `error_underrun` is asserted in the cycle after the underrun cycle.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). The partial frame is dropped by the arbiter. Resetting the bridge consistently is the integrator's responsibility.
- A single-beat frame (tvalid & tlast on the first beat) is legal: ACTIVE lasts one cycle when `m_axis_tready` = 1.

## Test plan
- Reset, then only port 2 valid with a 3-beat frame and tready = 1 → grant_index = 2; beats appear on m_axis in 3 consecutive cycles starting 1 cycle after the request; frame_count = 1; back in IDLE.
- All 4 ports continuously offering 2-beat frames → grant order 0,1,2,3,0,…; one bubble cycle between frames; frame_count = 8 after 8 frames.
- Port 1 granted, m_axis_tready toggled 1,0,1,0 → only port 1 sees tready; no beats lost or duplicated; other ports' tready stay 0.
- Port 0 granted, tvalid dropped for 3 cycles mid-frame → error_underrun high for exactly 3 cycles (each delayed by 1); grant held; frame completes.
- port_enable = 4'b1011 with all ports requesting → port 2 never granted. Clearing enable[0] mid-frame on port 0 → that frame still completes.
- rst asserted on beat 2 of a 4-beat frame → outputs clear immediately. After release with port 0 requesting, port 0 is granted first; frame_count = 0 before that frame and 1 after.

Source files
------------

// File: rtl/xgmii_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding the XGMII bridge TX stream.
// One source owns the stream from grant until its tlast beat is accepted.
module xgmii_tx_frame_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_WIDTH  = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  input  logic                             m_axis_tready,
  input  logic [NUM_PORTS-1:0]             port_enable,
  output logic                             grant_valid,
  output logic [IDX_WIDTH-1:0]             grant_index,
  output logic [31:0]                      frame_count,
  output logic                             error_underrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic [IDX_WIDTH-1:0]  last_grant;
  logic [NUM_PORTS-1:0]  req;
  logic                  active;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  beat_xfer;

  // First requester strictly after the previous winner, wrapping around.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(
    input logic [NUM_PORTS-1:0] r,
    input logic [IDX_WIDTH-1:0] last
  );
    logic [IDX_WIDTH-1:0] pick;
    logic [IDX_WIDTH-1:0] cand;
    logic                 found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_WIDTH'((int'(last) + k) % NUM_PORTS);
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req    = s_axis_tvalid & port_enable;
  assign active = (state == ACTIVE);

  // Zero-latency path from the granted source to the bridge.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_index == IDX_WIDTH'(i)) begin
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (active && (grant_index == IDX_WIDTH'(i))) begin
        s_axis_tready[i] = m_axis_tready;
      end
    end
  end

  assign m_axis_tvalid = active & sel_valid;
  assign m_axis_tdata  = sel_data;
  assign m_axis_tkeep  = sel_keep;
  assign m_axis_tlast  = sel_last;
  assign beat_xfer     = m_axis_tvalid & m_axis_tready;

  // Grant / frame bookkeeping; port_enable only matters while IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= IDX_WIDTH'(NUM_PORTS - 1);
      grant_index    <= '0;
      grant_valid    <= 1'b0;
      frame_count    <= '0;
      error_underrun <= 1'b0;
    end else begin
      error_underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_index <= rr_pick(req, last_grant);
            last_grant  <= rr_pick(req, last_grant);
            grant_valid <= 1'b1;
            state       <= ACTIVE;
          end
        end
        ACTIVE: begin
          error_underrun <= ~sel_valid;
          if (beat_xfer && sel_last) begin
            frame_count <= frame_count + 32'd1;
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_tx_frame_arbiter.sv
// Bench for xgmii_tx_frame_arbiter: per-port frame queues as sources and a
// frame-level ownership model predicting every output each cycle.
module tb_xgmii_tx_frame_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NP-1:0]      s_axis_tvalid = '0;
  logic [NP-1:0]      s_axis_tready;
  logic [NP*DW-1:0]   s_axis_tdata = '0;
  logic [NP-1:0]      s_axis_tlast = '0;
  logic [NP*KW-1:0]   s_axis_tkeep = '0;
  logic               m_axis_tvalid;
  logic [DW-1:0]      m_axis_tdata;
  logic               m_axis_tlast;
  logic [KW-1:0]      m_axis_tkeep;
  logic               m_axis_tready = 1'b0;
  logic [NP-1:0]      port_enable = '1;
  logic               grant_valid;
  logic [IW-1:0]      grant_index;
  logic [31:0]        frame_count;
  logic               error_underrun;

  always #5 clk = ~clk;

  xgmii_tx_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tready(m_axis_tready), .port_enable(port_enable),
    .grant_valid(grant_valid), .grant_index(grant_index),
    .frame_count(frame_count), .error_underrun(error_underrun)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t srcq [NP][$];

  int n_cmp = 0;
  int n_bad = 0;

  // Model: who owns the stream, who won last, counters.
  int          m_owner;
  logic [IW-1:0] m_last;
  logic [IW-1:0] m_gidx;
  logic [31:0] m_fc;
  logic        m_ur;

  logic          tready_k = 1'b1;
  logic [NP-1:0] en_k = '1;
  logic [NP-1:0] gap_mask = '0;
  bit            rand_gap_en = 1'b0;

  logic [NP-1:0] smp_v, smp_rdy, smp_en;
  logic          smp_mr;

  int   glog[$];
  logic prev_gv = 1'b0;
  int   ur_count = 0;
  int   seq = 0;
  int   pushed = 0;
  int   cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = IW'(NP - 1);
    m_gidx  = '0;
    m_fc    = '0;
    m_ur    = 1'b0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < NP; i++) srcq[i].delete();
    gap_mask    = '0;
    rand_gap_en = 1'b0;
  endtask

  task automatic push_frame(input int port, input int len);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d = {8'(port), 24'(seq), 32'($urandom())};
      b.l = (j == len - 1);
      b.k = b.l ? 8'($urandom_range(1, 255)) : 8'hff;
      seq++;
      srcq[port].push_back(b);
    end
  endtask

  task automatic drive_inputs();
    logic v;
    for (int i = 0; i < NP; i++) begin
      v = (srcq[i].size() > 0) && !gap_mask[i] &&
          !(rand_gap_en && ($urandom_range(0, 3) == 0));
      s_axis_tvalid[i] = v;
      if (srcq[i].size() > 0) begin
        s_axis_tdata[i*DW +: DW] = srcq[i][0].d;
        s_axis_tkeep[i*KW +: KW] = srcq[i][0].k;
        s_axis_tlast[i]          = srcq[i][0].l;
      end else begin
        s_axis_tdata[i*DW +: DW] = '0;
        s_axis_tkeep[i*KW +: KW] = '0;
        s_axis_tlast[i]          = 1'b0;
      end
    end
    m_axis_tready = tready_k;
    port_enable   = en_k;
  endtask

  task automatic compare_cycle();
    logic [NP-1:0] exp_rdy;
    logic          exp_mv;
    beat_t         b;
    exp_rdy = '0;
    exp_mv  = 1'b0;
    if (m_owner >= 0) begin
      exp_rdy[m_owner] = m_axis_tready;
      exp_mv           = s_axis_tvalid[m_owner];
    end
    check("grant_valid", 64'(grant_valid), 64'(m_owner >= 0));
    check("grant_index", 64'(grant_index), 64'(m_gidx));
    check("frame_count", 64'(frame_count), 64'(m_fc));
    check("error_underrun", 64'(error_underrun), 64'(m_ur));
    check("m_axis_tvalid", 64'(m_axis_tvalid), 64'(exp_mv));
    check("s_axis_tready", 64'(s_axis_tready), 64'(exp_rdy));
    if (exp_mv && srcq[m_owner].size() > 0) begin
      b = srcq[m_owner][0];
      check("m_axis_tdata", m_axis_tdata, b.d);
      check("m_axis_tkeep", 64'(m_axis_tkeep), 64'(b.k));
      check("m_axis_tlast", 64'(m_axis_tlast), 64'(b.l));
    end
    if (grant_valid && !prev_gv) glog.push_back(int'(grant_index));
    prev_gv = grant_valid;
    if (error_underrun) ur_count++;
    smp_v   = s_axis_tvalid;
    smp_rdy = s_axis_tready;
    smp_en  = port_enable;
    smp_mr  = m_axis_tready;
  endtask

  task automatic advance();
    int idx;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      m_ur = !smp_v[m_owner];
      if (smp_v[m_owner] && smp_mr && srcq[m_owner].size() > 0 && srcq[m_owner][0].l) begin
        m_fc    = m_fc + 32'd1;
        m_owner = -1;
      end
    end else begin
      m_ur = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        idx = (int'(m_last) + k) % NP;
        if (m_owner < 0 && smp_v[idx] && smp_en[idx]) begin
          m_owner = idx;
          m_last  = IW'(idx);
          m_gidx  = IW'(idx);
        end
      end
    end
    for (int i = 0; i < NP; i++)
      if (smp_v[i] && smp_rdy[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    advance();
    #1;
  endtask

  function automatic bit is_done();
    if (m_owner >= 0) return 1'b0;
    for (int i = 0; i < NP; i++)
      if (srcq[i].size() > 0 && en_k[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (!is_done()) begin
      if (cycles >= budget) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wait_idle timeout: got %0d cycles required < %0d", cycles, budget);
        break;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    clear_sources();
    glog.delete();
    ur_count = 0;
    tready_k = 1'b1;
    en_k     = '1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    apply_reset();

    // Reset state pinned to literals.
    check("rst grant_valid", 64'(grant_valid), 64'd0);
    check("rst grant_index", 64'(grant_index), 64'd0);
    check("rst frame_count", 64'(frame_count), 64'd0);
    check("rst m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst s_axis_tready", 64'(s_axis_tready), 64'd0);
    check("rst error_underrun", 64'(error_underrun), 64'd0);

    // Port 2 alone, 3 beats, then a single-beat frame on port 3.
    push_frame(2, 3);
    wait_idle(20, cyc);
    check("p2 cycles", 64'(cyc), 64'd4);
    check("p2 grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd2);
    check("p2 frame_count", 64'(frame_count), 64'd1);
    check("p2 idle", 64'(grant_valid), 64'd0);
    push_frame(3, 1);
    wait_idle(20, cyc);
    check("single cycles", 64'(cyc), 64'd2);
    check("single frame_count", 64'(frame_count), 64'd2);

    // All four ports, two 2-beat frames each.
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_frame(p, 2);
    wait_idle(100, cyc);
    check("rr cycles", 64'(cyc), 64'd24);
    check("rr frame_count", 64'(frame_count), 64'd8);
    check("rr grants", 64'(glog.size()), 64'd8);
    for (int j = 0; j < 8 && j < glog.size(); j++)
      check("rr order", 64'(glog[j]), 64'(j % NP));

    // Port 1 only enabled, tready toggling.
    apply_reset();
    en_k = 4'b0010;
    push_frame(1, 3);
    push_frame(0, 2);
    push_frame(2, 2);
    push_frame(3, 2);
    cyc = 0;
    while (!is_done() && cyc < 30) begin
      tready_k = (cyc % 2 == 1);
      tick();
      cyc++;
    end
    check("toggle cycles", 64'(cyc), 64'd6);
    check("toggle frame_count", 64'(frame_count), 64'd1);
    check("toggle grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd1);
    tready_k = 1'b1;

    // Underrun: port 0 stalls three cycles mid-frame.
    apply_reset();
    push_frame(0, 4);
    tick();
    tick();
    gap_mask = 4'b0001;
    tick();
    tick();
    tick();
    gap_mask = '0;
    wait_idle(20, cyc);
    check("underrun pulses", 64'(ur_count), 64'd3);
    check("underrun frame_count", 64'(frame_count), 64'd1);

    // Port 2 masked; then enable dropped mid-frame on port 0.
    apply_reset();
    en_k = 4'b1011;
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_frame(p, 2);
    wait_idle(100, cyc);
    check("mask frame_count", 64'(frame_count), 64'd6);
    for (int j = 0; j < glog.size(); j++) check("mask no port2", 64'(glog[j] == 2), 64'd0);
    check("mask order", 64'(glog.size() >= 3 ? glog[2] : -1), 64'd3);
    push_frame(0, 3);
    cyc = 0;
    while (m_owner != 0 && cyc < 10) begin
      tick();
      cyc++;
    end
    en_k = 4'b1010;
    wait_idle(20, cyc);
    check("mask mid-frame frame_count", 64'(frame_count), 64'd7);
    check("mask port0 drained", 64'(srcq[0].size()), 64'd0);

    // Asynchronous reset on the second beat of a 4-beat frame.
    apply_reset();
    push_frame(0, 4);
    cyc = 0;
    while (srcq[0].size() != 3 && cyc < 10) begin
      tick();
      cyc++;
    end
    #1 rst = 1'b1;
    #1;
    check("arst m_axis_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("arst s_axis_tready", 64'(s_axis_tready), 64'd0);
    check("arst grant_valid", 64'(grant_valid), 64'd0);
    check("arst frame_count", 64'(frame_count), 64'd0);
    model_reset();
    clear_sources();
    glog.delete();
    tick();
    tick();
    rst = 1'b0;
    check("arst count before", 64'(frame_count), 64'd0);
    push_frame(0, 2);
    push_frame(2, 2);
    cyc = 0;
    while (frame_count != 32'd1 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("arst first grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
    check("arst count after", 64'(frame_count), 64'd1);
    wait_idle(20, cyc);

    // Randomized traffic with stalls, gaps and enable changes.
    apply_reset();
    pushed = 0;
    rand_gap_en = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      tready_k = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) en_k = 4'($urandom_range(0, 15));
      for (int p = 0; p < NP; p++) begin
        if (srcq[p].size() < 4 && $urandom_range(0, 2) == 0) begin
          push_frame(p, $urandom_range(1, 5));
          pushed++;
        end
      end
      tick();
    end
    rand_gap_en = 1'b0;
    tready_k    = 1'b1;
    en_k        = '1;
    wait_idle(1000, cyc);
    check("random frame_count", 64'(frame_count), 64'(pushed));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
